// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encodings and default timing for the traffic controller
//
// Exports ped_state_t and emg_state_t, used by the request front end.
// Exports the default timing constants, which the controller also reads for its timers.
package traffic_pkg;

  typedef enum logic [1:0] {
    P_IDLE,
    P_PENDING,
    P_SERVING,
    P_COOLDOWN
  } ped_state_t;

  typedef enum logic [1:0] {
    E_OFF,
    E_ON,
    E_HOLD
  } emg_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_COOLDOWN_CYCLES = 10;
  localparam int DEF_EMG_HOLD_CYCLES = 8;

endpackage

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - 2-flop synchronizer, debounce and rising-edge detect for one raw input
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   raw_in      asynchronous raw field input
//   level_out   debounced level
//   rise_pulse  one-cycle pulse when level_out rises
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic             db_prev_q, db_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d   = raw_in;
    sync2_d   = sync1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    cnt_d     = '0;
    // Any cycle where the synchronized input agrees with db restarts the run.
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level_out  = db_q;
  assign rise_pulse = db_q & ~db_prev_q;

endmodule

// File: rtl/traffic_request_frontend.sv
// rtl/traffic_request_frontend.sv - conditions pedestrian button and emergency preempt for the controller
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   ped_button_raw      asynchronous pedestrian push-button
//   emg_preempt_raw     asynchronous emergency preemption contact
//   pedestrian_walk     grant from the controller, high while pedestrians cross
//   pedestrian_request  held request to the controller until walk is granted
//   emergency           emergency level with release hold
//   ped_wait_lamp       "request registered" indicator on the button housing
module traffic_request_frontend
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int EMG_HOLD_CYCLES = DEF_EMG_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ped_button_raw,
  input  logic emg_preempt_raw,
  input  logic pedestrian_walk,
  output logic pedestrian_request,
  output logic emergency,
  output logic ped_wait_lamp
);

  localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam int EH_W = $clog2(EMG_HOLD_CYCLES + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [EH_W-1:0] EH_LOAD = EH_W'(EMG_HOLD_CYCLES - 1);

  logic ped_level, ped_press;
  logic emg_level, emg_rise;

  // The pedestrian FSM needs only the press pulse, and the emergency FSM only the level.
  logic unused_cond;
  assign unused_cond = ped_level ^ emg_rise;

  input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ped_cond (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (ped_button_raw),
    .level_out  (ped_level),
    .rise_pulse (ped_press)
  );

  input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_emg_cond (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (emg_preempt_raw),
    .level_out  (emg_level),
    .rise_pulse (emg_rise)
  );

  ped_state_t      ped_state_q, ped_state_d;
  logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;
  logic            deferred_q, deferred_d;
  emg_state_t      emg_state_q, emg_state_d;
  logic [EH_W-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    ped_state_d = ped_state_q;
    cd_cnt_d    = cd_cnt_q;
    deferred_d  = deferred_q;
    case (ped_state_q)
      P_IDLE: begin
        if (ped_press) ped_state_d = P_PENDING;
      end
      P_PENDING: begin
        // A press coinciding with the grant is absorbed by the grant.
        if (pedestrian_walk) ped_state_d = P_SERVING;
      end
      P_SERVING: begin
        if (!pedestrian_walk) begin
          ped_state_d = P_COOLDOWN;
          cd_cnt_d    = CD_LOAD;
          deferred_d  = 1'b0;
        end
      end
      P_COOLDOWN: begin
        if (cd_cnt_q == '0) begin
          ped_state_d = (deferred_q || ped_press) ? P_PENDING : P_IDLE;
          deferred_d  = 1'b0;
        end else begin
          cd_cnt_d = cd_cnt_q - CD_W'(1);
          if (ped_press) deferred_d = 1'b1;
        end
      end
      default: ped_state_d = P_IDLE;
    endcase
  end

  always_comb begin
    emg_state_d = emg_state_q;
    hold_cnt_d  = hold_cnt_q;
    case (emg_state_q)
      E_OFF: begin
        if (emg_level) emg_state_d = E_ON;
      end
      E_ON: begin
        if (!emg_level) begin
          emg_state_d = E_HOLD;
          hold_cnt_d  = EH_LOAD;
        end
      end
      E_HOLD: begin
        // Re-assertion wins even on the final hold cycle.
        if (emg_level) begin
          emg_state_d = E_ON;
        end else if (hold_cnt_q == '0) begin
          emg_state_d = E_OFF;
        end else begin
          hold_cnt_d = hold_cnt_q - EH_W'(1);
        end
      end
      default: emg_state_d = E_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_state_q <= P_IDLE;
      cd_cnt_q    <= '0;
      deferred_q  <= 1'b0;
      emg_state_q <= E_OFF;
      hold_cnt_q  <= '0;
    end else begin
      ped_state_q <= ped_state_d;
      cd_cnt_q    <= cd_cnt_d;
      deferred_q  <= deferred_d;
      emg_state_q <= emg_state_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign pedestrian_request = (ped_state_q == P_PENDING);
  assign ped_wait_lamp      = (ped_state_q == P_PENDING) ||
                              ((ped_state_q == P_COOLDOWN) && deferred_q);
  assign emergency          = (emg_state_q != E_OFF);

endmodule

// File: doc/traffic_request_frontend.md
Name: traffic_request_frontend

Overview:
- Input-side front end for the traffic controller. It produces the controller's pedestrian_request and emergency inputs.
- It conditions two raw field inputs, the pedestrian push-button and the emergency-vehicle preemption contact: 2-flop synchronizer, then debounce.
- The pedestrian path holds a request until the controller grants it via pedestrian_walk, then enforces a cooldown.
- The emergency path adds a release hold so the controller never sees emergency chatter.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced level changes (>=1)
COOLDOWN_CYCLES, 10, cycles after walk ends during which new presses are deferred (>=1)
EMG_HOLD_CYCLES, 8, cycles emergency stays asserted after debounced preempt drops (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ped_button_raw  in  1  asynchronous push-button, active-high
emg_preempt_raw  in  1  asynchronous preemption contact, active-high
pedestrian_walk  in  1  grant from controller; high while pedestrians cross
pedestrian_request  out  1  level request to controller
emergency  out  1  level emergency to controller
ped_wait_lamp  out  1  "request registered" indicator on the button housing

Behaviour:
- Reset: clk is the clock; rst_n is synchronous, active-low. All sync flops, debounced levels, edge-detect flops, counters and FSMs clear. All outputs are 0 in the cycle after the reset edge. Reset mid-operation aborts any pending request, cooldown or hold.
- Synchronizer: 2 flops per raw input.
- Debounce: each input has a stable register db and a counter.
  - The counter increments on each edge at which sync output != db; it clears when they are equal.
  - db flips on the DEBOUNCE_CYCLES-th consecutive differing edge, and the counter clears.
  - A raw edge reaches db at edge 2+DEBOUNCE_CYCLES.
- Press: one-cycle pulse, db_ped & ~db_ped_q.
  - A button held across reset release counts as a press once debounced, because db resets to 0.
- Pedestrian FSM, registered state; outputs decoded from the state register only:
  - P_IDLE: request 0, lamp 0. Press -> P_PENDING. pedestrian_walk is ignored.
  - P_PENDING: request 1, lamp 1. pedestrian_walk=1 -> P_SERVING. Further presses are ignored.
  - P_SERVING: request 0, lamp 0. pedestrian_walk=0 -> P_COOLDOWN and the counter loads COOLDOWN_CYCLES-1. Presses are ignored.
  - P_COOLDOWN: request 0. lamp = deferred flag.
    - A press sets deferred.
    - The counter decrements each cycle. At 0, go to P_PENDING if deferred (or a press occurs that cycle), else P_IDLE. deferred clears on exit.
  - Total cooldown is exactly COOLDOWN_CYCLES cycles in P_COOLDOWN.
- Latency: raw button rise to pedestrian_request high is DEBOUNCE_CYCLES+3 edges. pedestrian_walk rise to request low is 1 edge.
- Emergency FSM:
  - E_OFF: emergency 0. db_emg=1 -> E_ON.
  - E_ON: emergency 1. db_emg=0 -> E_HOLD and the counter loads EMG_HOLD_CYCLES-1.
  - E_HOLD: emergency 1. db_emg=1 -> E_ON (re-arm). Counter 0 -> E_OFF. Otherwise decrement.
- Emergency and the pedestrian path are independent. A pending request stays held through emergency, so the controller re-serves it afterwards.
- Simultaneous events: press on the same cycle walk rises while in P_PENDING goes to P_SERVING and the press is dropped. A re-assert on the last hold cycle goes to E_ON.
- Counter widths are $clog2(param+1); counters never wrap, they saturate at 0.

Decomposition:
- traffic_pkg: ped_state_t {P_IDLE,P_PENDING,P_SERVING,P_COOLDOWN}, emg_state_t {E_OFF,E_ON,E_HOLD}, default timing constants. Shared with the controller for its timer constants.
- Sub-module input_conditioner (parameter DEBOUNCE_CYCLES; ports clk, rst_n, raw_in, level_out, rise_pulse) containing the synchronizer, debounce and edge detect. Instantiated twice.

Test Plan:
1. Defaults, reset released, ped_button_raw=1 held 20 cycles -> pedestrian_request and ped_wait_lamp rise at edge 7 and stay 1; emergency stays 0.
2. ped_button_raw pulsed high for 3 cycles, then high/low chatter alternating every 2 cycles for 20 cycles -> pedestrian_request never asserts.
3. Request pending; pedestrian_walk=1 at edge N -> request 0 at N+1. Walk=0 at edge M; press debounced at M+4 -> lamp 1 during cooldown, request re-asserts exactly at edge M+11; with no press -> returns to P_IDLE at M+11, request stays 0.
4. emg_preempt_raw high 3 cycles -> emergency stays 0. High 10 cycles starting edge T -> emergency 1 from T+7; raw falls at T+10 -> emergency stays 1 until T+17+8, then 0.
5. Emergency in E_HOLD, raw re-asserted for 10 cycles -> emergency never drops (returns to E_ON); pending pedestrian request stays 1 throughout.
6. rst_n=0 for 1 cycle while P_PENDING and E_ON -> all outputs 0 next edge. pedestrian_walk=1 while P_IDLE -> no change; request stays 0.
